// File: rtl/updown_counter.sv
// Loadable up/down counter with programmable top value, wrap/saturate boundary
// handling, a terminal-count pulse and a sticky overflow flag. The optional
// count prescaler is compiled in with UPDOWN_COUNTER_PRESCALE_EN.
module updown_counter #(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    parameter int              PRESCALE  = 4,
`endif
    parameter longint unsigned RESET_VAL = 64'd0
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter: WIDTH must be 1..32");
    end
    if (MAX_VAL == 64'd0 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("updown_counter: MAX_VAL must be 1..2**WIDTH-1");
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_reset
        $error("updown_counter: RESET_VAL must not exceed MAX_VAL");
    end

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_W = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH:0]   MAX_X = {1'b0, MAX_W};
    localparam logic [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step_s;
    logic [WIDTH:0]   out_x_s, inc_s, dec_s, data_x_s;
    logic             at_top_s, at_bot_s;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("updown_counter: PRESCALE must be at least 1");
    end

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    // Prescale phase: advances only on en cycles that win priority; clr/load restart it.
    always_comb begin
        ps_d = ps_q;
        if (clr || load) begin
            ps_d = {PS_W{1'b0}};
        end else if (en) begin
            ps_d = (ps_q == PS_LAST) ? {PS_W{1'b0}} : ps_q + PS_W'(1);
        end else begin
            ps_d = ps_q;
        end
    end

    // Prescale phase register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ps_q <= {PS_W{1'b0}};
        end else begin
            ps_q <= ps_d;
        end
    end

    assign step_s = en && (ps_q == PS_LAST);
`else
    assign step_s = en;
`endif

    // Extra top bit keeps the increment from aliasing when MAX_VAL is all ones.
    assign out_x_s  = {1'b0, out_q};
    assign data_x_s = {1'b0, data};
    assign inc_s    = out_x_s + ONE_X;
    assign dec_s    = out_x_s - ONE_X;
    assign at_top_s = (out_x_s >= MAX_X);
    assign at_bot_s = (out_q == {WIDTH{1'b0}});

    // Next-state: clr > load > counting step; tc is cleared unless a boundary is hit.
    always_comb begin
        out_d = out_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (clr) begin
            out_d = RST_W;
            ovf_d = 1'b0;
        end else if (load) begin
            out_d = (data_x_s > MAX_X) ? MAX_W : data;
        end else if (step_s) begin
            if (up) begin
                if (at_top_s) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    out_d = sat ? out_q : {WIDTH{1'b0}};
                end else begin
                    out_d = inc_s[WIDTH-1:0];
                end
            end else begin
                if (at_bot_s) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    out_d = sat ? out_q : MAX_W;
                end else begin
                    out_d = dec_s[WIDTH-1:0];
                end
            end
        end else begin
            out_d = out_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_q <= RST_W;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign out = out_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter (WIDTH=8, MAX_VAL=9, RESET_VAL=0):
// directed scenarios followed by random traffic against a behavioural model.
module tb_updown_counter;

    localparam int MAXV = 9;
    localparam int RSTV = 0;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0, sat = 1'b0;
    logic [7:0] data = 8'd0;
    logic [7:0] out;
    logic       tc, ovf;

    int checks = 0;
    int failures = 0;

    int m_out = RSTV;
    int m_tc  = 0;
    int m_ovf = 0;

    updown_counter #(.WIDTH(8), .MAX_VAL(MAXV), .RESET_VAL(RSTV)) dut (
        .clk(clk), .rstb(rstb), .clr(clr), .load(load), .data(data),
        .en(en), .up(up), .sat(sat), .out(out), .tc(tc), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference behaviour: one clock edge worth of the counter's rules.
    task automatic model_edge(input bit c, input bit l, input int d, input bit e, input bit u, input bit s);
        m_tc = 0;
        if (c) begin
            m_out = RSTV;
            m_ovf = 0;
        end else if (l) begin
            m_out = (d > MAXV) ? MAXV : d;
        end else if (e) begin
            if ((u && m_out == MAXV) || (!u && m_out == 0)) begin
                m_tc  = 1;
                m_ovf = 1;
                if (!s) m_out = u ? 0 : MAXV;
            end else begin
                m_out = u ? m_out + 1 : m_out - 1;
            end
        end
    endtask

    task automatic step(input bit c, input bit l, input logic [7:0] d, input bit e, input bit u, input bit s);
        clr = c; load = l; data = d; en = e; up = u; sat = s;
        model_edge(c, l, int'(d), e, u, s);
        @(posedge clk);
        #1;
        chk("out_model", 32'(out), 32'(m_out));
        chk("tc_model", 32'(tc), 32'(m_tc));
        chk("ovf_model", 32'(ovf), 32'(m_ovf));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 32'(out), 32'(RSTV));
        chk("rst_tc", 32'(tc), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        #2 rstb = 1'b1;

        // Wrap counting up: 1..9,0,1,2
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
            chk("wrap_up_out", 32'(out), 32'((i + 1) % 10));
            chk("wrap_up_tc", 32'(tc), (i == 9) ? 32'd1 : 32'd0);
            chk("wrap_up_ovf", 32'(ovf), (i >= 9) ? 32'd1 : 32'd0);
        end

        // Wrap counting down from 0: 9,8,7
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
            chk("wrap_dn_out", 32'(out), 32'(9 - i));
            chk("wrap_dn_tc", 32'(tc), (i == 0) ? 32'd1 : 32'd0);
        end

        // Saturate at the top
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'd8, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
            chk("sat_out", 32'(out), 32'd9);
            chk("sat_tc", 32'(tc), (i >= 1) ? 32'd1 : 32'd0);
        end
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        chk("clr_out", 32'(out), 32'd0);
        chk("clr_ovf", 32'(ovf), 32'd0);

        // Saturate at the bottom, then reverse direction at the top
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        chk("sat_bot_out", 32'(out), 32'd0);
        chk("sat_bot_tc", 32'(tc), 32'd1);
        step(1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        chk("rev_top_out", 32'(out), 32'd8);
        chk("rev_top_tc", 32'(tc), 32'd0);

        // Load clamping and priority
        step(1'b0, 1'b1, 8'd200, 1'b0, 1'b1, 1'b0);
        chk("load_clamp", 32'(out), 32'd9);
        step(1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
        chk("load_en_out", 32'(out), 32'd3);
        chk("load_en_tc", 32'(tc), 32'd0);
        step(1'b1, 1'b1, 8'd7, 1'b1, 1'b1, 1'b0);
        chk("clr_load_en", 32'(out), 32'd0);

        // Async reset mid-count with ovf set
        step(1'b0, 1'b1, 8'd9, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_out", 32'(out), 32'd5);
        chk("pre_rst_ovf", 32'(ovf), 32'd1);
        #2 rstb = 1'b0;
        #1;
        chk("async_rst_out", 32'(out), 32'd0);
        chk("async_rst_tc", 32'(tc), 32'd0);
        chk("async_rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_out", 32'(out), 32'd0);
        #2 rstb = 1'b1;
        m_out = RSTV; m_tc = 0; m_ovf = 0;
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        chk("resume_1", 32'(out), 32'd1);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        chk("resume_2", 32'(out), 32'd2);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                 8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
